comb_decimator: RTL and testbench



---
 rtl/dsp_pkg.sv | 32 +++
 rtl/sample_delay_line.sv | 30 +++
 rtl/comb_decimator.sv | 86 ++++++++
 tb/tb_comb_decimator.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/dsp_pkg.sv
// Shared helpers for the DSP datapath: constant log2 and the legal ranges
// used to reject bad CIC comb parameterisations at elaboration.
package dsp_pkg;

    localparam int DECIM_MIN = 1;
    localparam int DECIM_MAX = 256;
    localparam int DELAY_MIN = 1;
    localparam int DELAY_MAX = 8;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int span = 1; span < value; span = span * 2) begin
            result = result + 1;
        end
        return result;
    endfunction

    // A counter always needs at least one bit, even when it never leaves zero.
    function automatic int cnt_width(input int depth);
        return (clog2(depth) < 1) ? 1 : clog2(depth);
    endfunction

    function automatic bit decim_ok(input int decim);
        return (decim >= DECIM_MIN) && (decim <= DECIM_MAX);
    endfunction

    function automatic bit delay_ok(input int delay);
        return (delay >= DELAY_MIN) && (delay <= DELAY_MAX);
    endfunction

endpackage

// File: rtl/sample_delay_line.sv
// Shift-register delay line with synchronous zeroing; exposes the oldest tap.
module sample_delay_line #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             shift,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout_oldest
);

    logic [WIDTH-1:0] taps [DEPTH];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                taps[i] <= '0;
            end
        end else if (shift) begin
            taps[0] <= din;
            for (int i = 1; i < DEPTH; i++) begin
                taps[i] <= taps[i-1];
            end
        end
    end

    assign dout_oldest = taps[DEPTH-1];

endmodule

// File: rtl/comb_decimator.sv
// CIC comb stage: keeps every DECIM-th accepted sample and outputs the modular
// difference against the kept sample DIFF_DELAY positions earlier.
module comb_decimator
    import dsp_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int DECIM      = 4,
    parameter int DIFF_DELAY = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  in_valid,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic                  out_valid,
    output logic [DATA_WIDTH-1:0] data_out
);

    localparam int CNT_W = cnt_width(DECIM);
    localparam logic [CNT_W-1:0] LAST_PHASE = CNT_W'(DECIM - 1);

    if (!decim_ok(DECIM)) begin : g_bad_decim
        $error("comb_decimator: DECIM must lie in 1..256");
    end

    if (!delay_ok(DIFF_DELAY)) begin : g_bad_delay
        $error("comb_decimator: DIFF_DELAY must lie in 1..8");
    end

    // Wrap-around is intentional: CIC integrator growth cancels modulo 2^N.
    function automatic logic signed [DATA_WIDTH-1:0] wrap_sub(
        input logic signed [DATA_WIDTH-1:0] minuend,
        input logic signed [DATA_WIDTH-1:0] subtrahend
    );
        return minuend - subtrahend;
    endfunction

    logic [CNT_W-1:0]             count_p0;
    logic                         accept_p0;
    logic                         keep_p0;
    logic signed [DATA_WIDTH-1:0] sample_p0;
    logic signed [DATA_WIDTH-1:0] oldest_p0;
    logic signed [DATA_WIDTH-1:0] diff_p1;
    logic                         vld_p1;

    // Stage p0: accept, decimation phase and delay-line tap.
    assign accept_p0 = en && in_valid && !rst;
    assign keep_p0   = accept_p0 && (count_p0 == LAST_PHASE);
    assign sample_p0 = data_in;

    always_ff @(posedge clk) begin
        if (rst) begin
            count_p0 <= '0;
        end else if (accept_p0) begin
            count_p0 <= keep_p0 ? '0 : count_p0 + CNT_W'(1);
        end
    end

    sample_delay_line #(
        .WIDTH (DATA_WIDTH),
        .DEPTH (DIFF_DELAY)
    ) u_delay (
        .clk         (clk),
        .rst         (rst),
        .shift       (keep_p0),
        .din         (data_in),
        .dout_oldest (oldest_p0)
    );

    // Stage p1: registered difference and one-cycle valid pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p1  <= 1'b0;
            diff_p1 <= '0;
        end else begin
            vld_p1 <= keep_p0;
            if (keep_p0) begin
                diff_p1 <= wrap_sub(sample_p0, oldest_p0);
            end
        end
    end

    assign out_valid = vld_p1;
    assign data_out  = diff_p1;

endmodule

// File: tb/tb_comb_decimator.sv
// Bench for comb_decimator: four parameterisations share one stimulus stream
// and are compared each cycle against a kept-sample history model.
module tb_comb_decimator;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic       in_valid;
    logic [7:0] data_in;
    logic [3:0] ov;
    logic [7:0] dout [4];

    always #5 clk = ~clk;

    comb_decimator #(.DATA_WIDTH(8), .DECIM(1), .DIFF_DELAY(1)) u_a (
        .clk(clk), .rst(rst), .en(en), .in_valid(in_valid), .data_in(data_in),
        .out_valid(ov[0]), .data_out(dout[0]));
    comb_decimator #(.DATA_WIDTH(8), .DECIM(4), .DIFF_DELAY(1)) u_b (
        .clk(clk), .rst(rst), .en(en), .in_valid(in_valid), .data_in(data_in),
        .out_valid(ov[1]), .data_out(dout[1]));
    comb_decimator #(.DATA_WIDTH(8), .DECIM(1), .DIFF_DELAY(2)) u_c (
        .clk(clk), .rst(rst), .en(en), .in_valid(in_valid), .data_in(data_in),
        .out_valid(ov[2]), .data_out(dout[2]));
    comb_decimator #(.DATA_WIDTH(8), .DECIM(3), .DIFF_DELAY(3)) u_d (
        .clk(clk), .rst(rst), .en(en), .in_valid(in_valid), .data_in(data_in),
        .out_valid(ov[3]), .data_out(dout[3]));

    int         checks = 0;
    int         errors = 0;
    int         nacc  [4];
    int         nkept [4];
    logic [7:0] kept  [4][256];
    logic [7:0] exp_d [4];
    logic       exp_v [4];

    function automatic int r_of(input int i);
        case (i)
            1:       return 4;
            3:       return 3;
            default: return 1;
        endcase
    endfunction

    function automatic int m_of(input int i);
        case (i)
            2:       return 2;
            3:       return 3;
            default: return 1;
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    // Every DECIM-th accepted sample since reset is kept; output is that sample
    // minus the kept sample M positions back (zero if none yet).
    task automatic model_edge(input logic r, input logic e, input logic v, input logic [7:0] d);
        logic [7:0] prev;
        for (int i = 0; i < 4; i++) begin
            if (r) begin
                nacc[i]  = 0;
                nkept[i] = 0;
                exp_d[i] = 8'd0;
                exp_v[i] = 1'b0;
            end else if (e && v) begin
                nacc[i]++;
                if (nacc[i] % r_of(i) == 0) begin
                    prev = (nkept[i] >= m_of(i)) ? kept[i][(nkept[i] - m_of(i)) % 256] : 8'd0;
                    exp_d[i] = d - prev;
                    kept[i][nkept[i] % 256] = d;
                    nkept[i]++;
                    exp_v[i] = 1'b1;
                end else begin
                    exp_v[i] = 1'b0;
                end
            end else begin
                exp_v[i] = 1'b0;
            end
        end
    endtask

    task automatic step(input logic r, input logic e, input logic v, input logic [7:0] d);
        rst = r; en = e; in_valid = v; data_in = d;
        @(posedge clk);
        model_edge(r, e, v, d);
        #1;
        for (int i = 0; i < 4; i++) begin
            check($sformatf("out_valid[%0d]", i), 32'(ov[i]), 32'(exp_v[i]));
            check($sformatf("data_out[%0d]", i), 32'(dout[i]), 32'(exp_d[i]));
        end
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; in_valid = 1'b0; data_in = 8'd0;

        step(1, 0, 0, 8'd0);
        step(1, 1, 1, 8'd55);
        check("reset_valid_a", 32'(ov[0]), 32'd0);
        check("reset_data_b", 32'(dout[1]), 32'd0);

        // Ramp 3,6,9,12 on DECIM=1, M=1 gives a constant step of 3.
        step(0, 1, 1, 8'd3);
        check("ramp_first_raw", 32'(dout[0]), 32'd3);
        step(0, 1, 1, 8'd6);
        step(0, 1, 1, 8'd9);
        step(0, 1, 1, 8'd12);
        check("ramp_step", 32'(dout[0]), 32'd3);
        check("ramp_back_to_back", 32'(ov[0]), 32'd1);
        step(0, 1, 0, 8'd0);
        check("ramp_pulse_ends", 32'(ov[0]), 32'd0);

        // Modular wrap: 250,254,2,6 -> 250,4,4,4.
        step(1, 0, 0, 8'd0);
        step(0, 1, 1, 8'd250);
        check("wrap_first", 32'(dout[0]), 32'd250);
        step(0, 1, 1, 8'd254);
        step(0, 1, 1, 8'd2);
        check("wrap_across_zero", 32'(dout[0]), 32'd4);
        step(0, 1, 1, 8'd6);

        // Inputs 0..11 on DECIM=4 keep 3,7,11 -> 3,4,4; DECIM=1,M=2 also exercised.
        step(1, 0, 0, 8'd0);
        for (int k = 0; k < 12; k++) begin
            step(0, 1, 1, 8'(k));
            if (k == 3) check("decim_first_kept", 32'(dout[1]), 32'd3);
            if (k == 10) check("decim_no_pulse", 32'(ov[1]), 32'd0);
            if (k == 11) check("decim_third_kept", 32'(dout[1]), 32'd4);
        end

        // DECIM=1, M=2: 5,10,15,20 -> 5,10,10,10.
        step(1, 0, 0, 8'd0);
        step(0, 1, 1, 8'd5);
        step(0, 1, 1, 8'd10);
        check("m2_warmup", 32'(dout[2]), 32'd10);
        step(0, 1, 1, 8'd15);
        step(0, 1, 1, 8'd20);
        check("m2_steady", 32'(dout[2]), 32'd10);

        // Enable gated for three cycles with in_valid held high.
        step(1, 0, 0, 8'd0);
        for (int k = 0; k < 14; k++) begin
            step(0, !(k >= 5 && k <= 7), 1, 8'(k * 7));
            if (k == 6) check("gated_no_pulse", 32'(ov[0]), 32'd0);
        end

        // Reset mid-stream on DECIM=4 discards the coincident sample and rephases.
        step(1, 0, 0, 8'd0);
        step(0, 1, 1, 8'd1);
        step(0, 1, 1, 8'd2);
        step(1, 1, 1, 8'd99);
        check("midrst_valid", 32'(ov[1]), 32'd0);
        check("midrst_data", 32'(dout[2]), 32'd0);
        step(0, 1, 1, 8'd40);
        step(0, 1, 1, 8'd41);
        step(0, 1, 1, 8'd42);
        check("midrst_not_yet", 32'(ov[1]), 32'd0);
        step(0, 1, 1, 8'd43);
        check("midrst_kept_raw", 32'(dout[1]), 32'd43);
        check("midrst_kept_valid", 32'(ov[1]), 32'd1);

        // Randomised traffic with sporadic enables, gaps and resets.
        step(1, 0, 0, 8'd0);
        for (int k = 0; k < 400; k++) begin
            step($urandom_range(0, 39) == 0, $urandom_range(0, 7) != 0,
                 $urandom_range(0, 3) != 0, 8'($urandom));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
